// File: rtl/uart_receiver_if.sv
// Parallel-side bundle of the UART receiver: serial line in, byte/done/error/state out.
// master = the receiver itself, slave = whoever drives the line and consumes the bytes.
interface uart_receiver_if #(
    parameter int NB_BYTE  = 8,
    parameter int NB_STATE = 3
);
    logic                i_rx;
    logic [NB_BYTE-1:0]  o_rx_data;
    logic                o_rx_done;
    logic                o_framing_error;
    logic [NB_STATE-1:0] o_state;

    modport master (
        input  i_rx,
        output o_rx_data,
        output o_rx_done,
        output o_framing_error,
        output o_state
    );

    modport slave (
        output i_rx,
        input  o_rx_data,
        input  o_rx_done,
        input  o_framing_error,
        input  o_state
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled, byte + 1-cycle done pulse per good frame, bad stop bit flagged.
// Latency: start edge -> done ~ 2 clk + (1.5 + NB_BYTE) bit periods + 1 clk; no backpressure, pulses are unconditional.
module uart_receiver #(
    parameter int NB_BYTE       = 8,
    parameter int CLKS_PER_TICK = 650,
    parameter int OVERSAMPLE    = 16,
    parameter int NB_STATE      = 3
) (
    input  logic            i_clock,
    input  logic            i_reset,
    uart_receiver_if.master rx_if
);
    localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int S_W    = $clog2(OVERSAMPLE);
    localparam int IDX_W  = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_TICK - 1);
    localparam logic [S_W-1:0]    S_MID    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]    S_END    = S_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NB_BYTE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [S_W-1:0]     s_cnt_q, s_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_BYTE-1:0] shift_q, shift_d;
    logic [NB_BYTE-1:0] rx_data_q, rx_data_d;
    logic               rx_done_q, rx_done_d;
    logic               ferr_q, ferr_d;

    logic tick;
    logic s_at_mid;
    logic s_at_end;

    always_comb begin
        rx_meta_d = rx_if.i_rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_done_d = 1'b0;
        ferr_d    = 1'b0;

        tick     = (tick_cnt_q == TICK_MAX);
        s_at_mid = (s_cnt_q == S_MID);
        s_at_end = (s_cnt_q == S_END);

        // Holding the tick counter at zero in IDLE aligns sample phase to the start edge.
        if (state_q == ST_IDLE || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick && s_at_mid) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick && s_at_end) begin
                    shift_d = {rx_s_q, shift_q[NB_BYTE-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick && s_at_end) begin
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            s_cnt_d = '0;
        end else if (tick) begin
            s_cnt_d = s_at_end ? '0 : s_cnt_q + 1'b1;
        end else begin
            s_cnt_d = s_cnt_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            s_cnt_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            tick_cnt_q <= tick_cnt_d;
            s_cnt_q    <= s_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_if.o_rx_data       = rx_data_q;
    assign rx_if.o_rx_done       = rx_done_q;
    assign rx_if.o_framing_error = ferr_q;
    assign rx_if.o_state         = NB_STATE'(state_q);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one fast instance (4 clk/tick, x16) and one slow (650 clk/tick, x4).
module tb_uart_receiver;
    localparam int CPT      = 4;
    localparam int OS       = 16;
    localparam int BIT      = CPT * OS;
    localparam int CPT_SLOW = 650;
    localparam int OS_SLOW  = 4;
    localparam int BIT_SLOW = CPT_SLOW * OS_SLOW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_receiver_if #(.NB_BYTE(8), .NB_STATE(3)) rif ();
    uart_receiver_if #(.NB_BYTE(8), .NB_STATE(3)) sif ();

    uart_receiver #(.NB_BYTE(8), .CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .NB_STATE(3)) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .rx_if   (rif.master)
    );

    uart_receiver #(.NB_BYTE(8), .CLKS_PER_TICK(CPT_SLOW), .OVERSAMPLE(OS_SLOW), .NB_STATE(3)) u_dut_slow (
        .i_clock (clk),
        .i_reset (rst),
        .rx_if   (sif.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Event log built on the falling edge; tasks compare deltas against snapshots.
    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         slow_done = 0;
    logic [7:0] data_log[$];
    logic [7:0] slow_log[$];
    int         st_cycles[8];

    always @(negedge clk) begin
        if (rif.o_rx_done) begin
            done_cnt <= done_cnt + 1;
            data_log.push_back(rif.o_rx_data);
        end
        if (rif.o_framing_error) ferr_cnt <= ferr_cnt + 1;
        if (rif.o_rx_done && rif.o_framing_error) both_cnt <= both_cnt + 1;
        st_cycles[rif.o_state] <= st_cycles[rif.o_state] + 1;
        if (sif.o_rx_done) begin
            slow_done <= slow_done + 1;
            slow_log.push_back(sif.o_rx_data);
        end
    end

    task automatic set_line(input bit slow, input logic v);
        if (slow) sif.i_rx = v;
        else      rif.i_rx = v;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit slow, input logic [7:0] b, input logic stop_bit);
        int bit_clks;
        bit_clks = slow ? BIT_SLOW : BIT;
        set_line(slow, 1'b0);
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            set_line(slow, b[i]);
            wait_clks(bit_clks);
        end
        set_line(slow, stop_bit);
        wait_clks(bit_clks);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(5);
        vectors++;
        if (rif.o_rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00", rif.o_rx_data);
        end
        vectors++;
        if (rif.o_rx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", rif.o_rx_done);
        end
        vectors++;
        if (rif.o_framing_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ferr: got %b want 0", rif.o_framing_error);
        end
        vectors++;
        if (rif.o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d want 0", rif.o_state);
        end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_single();
        int d0;
        d0 = done_cnt;
        send_frame(1'b0, 8'h55, 1'b1);
        wait_clks(2 * BIT);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL single_done_count: got %0d want 1", done_cnt - d0);
        end else begin
            vectors++;
            if (data_log[d0] !== 8'h55) begin
                miscompares++;
                $display("FAIL single_pulse_data: got %h want 55", data_log[d0]);
            end
        end
        vectors++;
        if (rif.o_rx_data !== 8'h55) begin
            miscompares++;
            $display("FAIL single_hold_data: got %h want 55", rif.o_rx_data);
        end
        vectors++;
        if (rif.o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL single_state: got %0d want 0", rif.o_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bytes[4];
        int d0;
        exp_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_frame(1'b0, exp_bytes[i], 1'b1);
        wait_clks(2 * BIT);
        vectors++;
        if (done_cnt - d0 !== 4) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d want 4", done_cnt - d0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (data_log[d0 + i] !== exp_bytes[i]) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", i, data_log[d0 + i], exp_bytes[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int d0, f0, s_start, s_data;
        d0 = done_cnt;
        f0 = ferr_cnt;
        s_start = st_cycles[1];
        s_data  = st_cycles[2];
        rif.i_rx = 1'b0;
        wait_clks(3 * CPT);
        rif.i_rx = 1'b1;
        wait_clks(2 * BIT);
        vectors++;
        if (st_cycles[1] == s_start) begin
            miscompares++;
            $display("FAIL glitch_entered_start: got 0 START cycles want >0");
        end
        vectors++;
        if (st_cycles[2] !== s_data) begin
            miscompares++;
            $display("FAIL glitch_no_data: got %0d DATA cycles want 0", st_cycles[2] - s_data);
        end
        vectors++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_no_pulse: got done %0d ferr %0d want 0 0", done_cnt - d0, ferr_cnt - f0);
        end
        vectors++;
        if (rif.o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL glitch_state: got %0d want 0", rif.o_state);
        end
    endtask

    task automatic test_framing();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(1'b0, 8'h11, 1'b0);
        wait_clks(2 * BIT);
        vectors++;
        if (rif.o_state !== 3'd4) begin
            miscompares++;
            $display("FAIL ferr_state_break: got %0d want 4", rif.o_state);
        end
        vectors++;
        if (ferr_cnt - f0 !== 1) begin
            miscompares++;
            $display("FAIL ferr_pulse_count: got %0d want 1", ferr_cnt - f0);
        end
        vectors++;
        if (done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0);
        end
        vectors++;
        if (rif.o_rx_data !== 8'hDD) begin
            miscompares++;
            $display("FAIL ferr_data_kept: got %h want dd", rif.o_rx_data);
        end
        rif.i_rx = 1'b1;
        wait_clks(BIT);
        vectors++;
        if (rif.o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL ferr_break_exit: got %0d want 0", rif.o_state);
        end
        send_frame(1'b0, 8'h22, 1'b1);
        wait_clks(2 * BIT);
        vectors++;
        if (done_cnt - d0 !== 1 || rif.o_rx_data !== 8'h22) begin
            miscompares++;
            $display("FAIL ferr_recover: got %0d done data %h want 1 done data 22", done_cnt - d0, rif.o_rx_data);
        end
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL pulses_exclusive: got %0d overlaps want 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0;
        logic [7:0] b;
        b = 8'hFF;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rif.i_rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rif.i_rx = b[i];
            wait_clks(BIT);
        end
        rif.i_rx = b[4];
        wait_clks(BIT / 2);
        rst = 1'b1;
        wait_clks(3);
        vectors++;
        if (rif.o_state !== 3'd0 || rif.o_rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_outputs: got state %0d data %h want 0 00", rif.o_state, rif.o_rx_data);
        end
        rst = 1'b0;
        wait_clks(BIT / 2 + 4 * BIT);
        wait_clks(2 * BIT);
        vectors++;
        if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_pulse: got done %0d ferr %0d want 0 0", done_cnt - d0, ferr_cnt - f0);
        end
        send_frame(1'b0, 8'h01, 1'b1);
        wait_clks(2 * BIT);
        vectors++;
        if (done_cnt - d0 !== 1 || rif.o_rx_data !== 8'h01) begin
            miscompares++;
            $display("FAIL midreset_next_frame: got %0d done data %h want 1 done data 01", done_cnt - d0, rif.o_rx_data);
        end
    endtask

    task automatic test_slow_baud();
        int d0;
        d0 = slow_done;
        send_frame(1'b1, 8'h01, 1'b1);
        wait_clks(BIT_SLOW);
        vectors++;
        if (slow_done - d0 !== 1) begin
            miscompares++;
            $display("FAIL slow_done_count: got %0d want 1", slow_done - d0);
        end else begin
            vectors++;
            if (slow_log[d0] !== 8'h01) begin
                miscompares++;
                $display("FAIL slow_data: got %h want 01", slow_log[d0]);
            end
        end
        vectors++;
        if (sif.o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL slow_state: got %0d want 0", sif.o_state);
        end
    endtask

    initial begin
        rif.i_rx = 1'b1;
        sif.i_rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_slow_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
